// File: rtl/neuron_feed_if.sv
// Sample word type plus the stream/sample bundle between the feeder and its neighbours.
// No logic here: zero2one_t is an unsigned 0..1 fixed-point value, 8 fractional bits.
// slave = feeder (consumes stream, drives sample); master = upstream/downstream side.
package neuron_feed_pkg;
    typedef logic [7:0] zero2one_t;
endpackage

interface neuron_feed_if #(
    parameter int N = 16
) ();
    import neuron_feed_pkg::*;

    logic                  s_valid;
    logic                  s_ready;
    zero2one_t             s_data;
    logic                  s_last;

    logic                  valid;
    logic                  learn;
    zero2one_t [N-1:0]     in;
    zero2one_t             expected_out;

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready,
        output valid, learn, in, expected_out
    );

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready,
        input  valid, learn, in, expected_out
    );
endinterface

// File: rtl/neuron_feed.sv
// Assembles N stream words + one s_last expected word into a parallel training sample; NEURON_FEED_STATS_EN adds frame/error counters.
// Latency: valid rises 1 cycle after the last word is accepted, held max(hold_cycles,1) cycles, then 1 gap cycle.
// Backpressure: s_ready is registered and low while presenting/gapping; malformed frames are dropped with a frame_err pulse.
module neuron_feed
    import neuron_feed_pkg::*;
#(
    parameter int N      = 16,
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    neuron_feed_if.slave      bus,
    input  logic              learn_en,
    input  logic [HOLD_W-1:0] hold_cycles,
    output logic              frame_err
`ifdef NEURON_FEED_STATS_EN
    ,
    output logic [15:0]       frame_cnt,
    output logic [7:0]        err_cnt
`endif
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        FILL,
        EXPECT,
        DRAIN,
        PRESENT,
        GAP
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    zero2one_t [N-1:0] in_q, in_d;
    zero2one_t         exp_q, exp_d;
    logic              learn_q, learn_d;
    logic              valid_q, valid_d;
    logic              s_ready_q, s_ready_d;
    logic              frame_err_q, frame_err_d;
    logic              accept;

`ifdef NEURON_FEED_STATS_EN
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
`endif

    assign accept = bus.s_valid && s_ready_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        in_d        = in_q;
        exp_d       = exp_q;
        learn_d     = learn_q;
        frame_err_d = 1'b0;

        case (state_q)
            FILL: begin
                if (accept) begin
                    if (bus.s_last) begin
                        // Early last: in[] keeps whatever was overwritten so far.
                        frame_err_d = 1'b1;
                        idx_d       = '0;
                    end else begin
                        in_d[idx_q] = bus.s_data;
                        if (idx_q == IDX_W'(N - 1)) begin
                            idx_d   = '0;
                            state_d = EXPECT;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
            end
            EXPECT: begin
                if (accept) begin
                    if (bus.s_last) begin
                        exp_d   = bus.s_data;
                        learn_d = learn_en;
                        cnt_d   = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
                        state_d = PRESENT;
                    end else begin
                        frame_err_d = 1'b1;
                        idx_d       = '0;
                        state_d     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (accept && bus.s_last) begin
                    idx_d   = '0;
                    state_d = FILL;
                end
            end
            PRESENT: begin
                if (cnt_q <= HOLD_W'(1)) begin
                    cnt_d   = '0;
                    learn_d = 1'b0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end
            end
            GAP: begin
                idx_d   = '0;
                state_d = FILL;
            end
            default: begin
                idx_d   = '0;
                state_d = FILL;
            end
        endcase

        // Handshake/valid flops follow the next state so they line up with it.
        s_ready_d = (state_d == FILL) || (state_d == EXPECT) || (state_d == DRAIN);
        valid_d   = (state_d == PRESENT);
    end

`ifdef NEURON_FEED_STATS_EN
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (state_q == EXPECT && state_d == PRESENT) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if (frame_err_d && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            idx_q       <= '0;
            cnt_q       <= '0;
            in_q        <= '0;
            exp_q       <= '0;
            learn_q     <= 1'b0;
            valid_q     <= 1'b0;
            s_ready_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            in_q        <= in_d;
            exp_q       <= exp_d;
            learn_q     <= learn_d;
            valid_q     <= valid_d;
            s_ready_q   <= s_ready_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.s_ready      = s_ready_q;
    assign bus.valid        = valid_q;
    assign bus.learn        = learn_q;
    assign bus.in           = in_q;
    assign bus.expected_out = exp_q;
    assign frame_err        = frame_err_q;

endmodule

// File: doc/neuron_feed.md
Name: neuron_feed

Overview:
- Upstream stage of neuron_learn. Assembles one training sample from a serial word stream: N input words followed by one expected-output word.
- Presents the sample in parallel (in[], expected_out) with valid/learn held stable for a programmable number of cycles, then deasserts valid so the neuron runs its randomisation step between samples.
- Detects and discards malformed frames.

Parameters:
- N, 16, number of neuron inputs per sample; must match the downstream neuron_learn N.
- HOLD_W, 8, width of the hold-cycle count input.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  stream word valid.
- s_ready  output  1  stream word accepted when s_valid && s_ready.
- s_data  input  $bits(zero2one_t)  stream word: input value or expected output.
- s_last  input  1  marks the expected-output word, which closes the frame.
- learn_en  input  1  learn request; sampled at frame completion.
- hold_cycles  input  HOLD_W  present-phase length in cycles; 0 is treated as 1.
- valid  output  1  sample valid to neuron_learn.
- learn  output  1  learn flag to neuron_learn.
- in  output  zero2one_t [N-1:0]  assembled inputs; in[0] is the first word of the frame.
- expected_out  output  zero2one_t  expected-output word.
- frame_err  output  1  one-cycle pulse when a malformed frame is discarded.

Behaviour:
- Reset (asynchronous, rst_n=0): state=FILL, idx=0, hold counter=0, valid=0, learn=0, s_ready=0, every in[i]=0, expected_out=0, frame_err=0. s_ready is registered and rises on the first clk edge after rst_n deasserts.
- FILL:
  - s_ready=1. On each accepted word with s_last=0: in[idx]<=s_data, idx++.
  - When idx reaches N, go to EXPECT.
  - Accepted word with s_last=1 while idx<N is an early-last error: pulse frame_err, idx<=0, stay in FILL. in[] keeps its partially overwritten contents; valid stays 0.
- EXPECT:
  - s_ready=1. Accepted word with s_last=1: expected_out<=s_data, learn<=learn_en, latch hold count max(hold_cycles,1), go to PRESENT.
  - Accepted word with s_last=0 is a missing-last error: pulse frame_err, idx<=0, go to DRAIN.
- DRAIN: s_ready=1. Discard words until an accepted s_last=1 word, then go to FILL with idx=0. No frame_err pulse on exit.
- PRESENT:
  - s_ready=0, valid=1. in/expected_out/learn held constant.
  - Counter decrements each cycle; at 1 go to GAP.
  - valid is asserted for exactly max(hold_cycles,1) cycles, starting the cycle after the EXPECT-accepting edge.
- GAP: exactly one cycle with valid=0, s_ready=0; learn forced 0. Then FILL with idx=0.
- Latency: from the accepting edge of the last word to valid=1 is 1 cycle.
- Minimum frame period: N+1 accept cycles, then the hold cycles, then 1 gap cycle.
- Once latched, learn_en and hold_cycles changes have no effect until the next frame completes.
- s_valid=0 in any state: no state change except the PRESENT/GAP countdown.
- All outputs are registered; there is no combinational path from s_* to valid/in/expected_out. s_ready is a function of state only.
- Reset asserted mid-frame or mid-PRESENT: immediate return to reset values; the partial frame is lost.

Optional Feature:
- Macro NEURON_FEED_STATS_EN adds output frame_cnt (16 bits) and err_cnt (8 bits).
- frame_cnt increments on each EXPECT to PRESENT transition and wraps 0xFFFF to 0.
- err_cnt increments on each frame_err pulse and saturates at 0xFF.
- Both counters reset to 0.
- Without the macro the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- N=4, hold_cycles=3, learn_en=1; stream 1,2,3,0 then 3 with s_last -> in={1,2,3,0} with in[0]=1, expected_out=3, learn=1; valid=1 for exactly 3 cycles starting 1 cycle after the last accept; then 1 gap cycle; s_ready=1 again.
- hold_cycles=0 -> valid high exactly 1 cycle.
- Early last: 2 words, then s_last on the 3rd -> frame_err single pulse, valid never asserts; a following good frame presents correctly.
- Missing last: 5 words with no s_last, then junk, then s_last -> frame_err once, junk discarded up to and including the s_last word; the next 5-word frame is presented.
- s_valid toggling every other cycle during FILL -> same in[] as back-to-back; no words dropped or duplicated.
- rst_n pulsed low during PRESENT -> valid=0 and in[]=0 asynchronously; with NEURON_FEED_STATS_EN, 2 good frames plus 1 bad frame give frame_cnt=2, err_cnt=1.
